// File: rtl/spi_sclk_burst_gen.sv
// SPI serial-clock burst generator: emits N SCLK periods at a runtime divisor,
// with lead/trail edge strobes and a start/busy/done handshake.
module spi_sclk_burst_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CYC_W = 8
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] divisor,
  input  logic [CYC_W-1:0] n_cycles,
  input  logic             cpol,
  input  logic             stop,
  output logic             clock_out,
  output logic             lead_tick,
  output logic             trail_tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CYC_W-1:0] rem_q, rem_d;
  logic             cpol_q, cpol_d;
  logic             stop_q, stop_d;
  logic             clk_q, clk_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] half_d;
  logic [CYC_W-1:0] rem_dec;
  logic             stop_seen;

  // Next-state logic; outputs are computed from the next state so every
  // output is a plain flop in the cycle it describes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    rem_d     = rem_q;
    cpol_d    = cpol_q;
    stop_d    = stop_q;
    trail_d   = 1'b0;
    done_d    = 1'b0;
    rem_dec   = rem_q - CYC_W'(1);
    stop_seen = stop_q | stop;

    unique case (state_q)
      IDLE: begin
        cpol_d = cpol;
        if (start) begin
          div_d = (divisor < CNT_W'(2)) ? CNT_W'(2) : divisor;
          rem_d = n_cycles;
          if (n_cycles == CYC_W'(0)) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_W'(0);
            stop_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (cnt_q == div_q - CNT_W'(1)) begin
          rem_d   = rem_dec;
          trail_d = 1'b1;
          cnt_d   = CNT_W'(0);
          stop_d  = 1'b0;
          if ((rem_dec == CYC_W'(0)) || stop_seen) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          stop_d = stop_seen;
        end
      end
      default: state_d = IDLE;
    endcase

    half_d = div_d >> 1;
    busy_d = (state_d == RUN);
    if (state_d == RUN) begin
      clk_d  = (cnt_d < half_d) ? cpol_d : ~cpol_d;
      lead_d = (cnt_d == half_d);
    end else begin
      clk_d  = cpol_d;
      lead_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(2);
      rem_q   <= '0;
      cpol_q  <= 1'b0;
      stop_q  <= 1'b0;
      clk_q   <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cpol_q  <= cpol_d;
      stop_q  <= stop_d;
      clk_q   <= clk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign clock_out  = clk_q;
  assign lead_tick  = lead_q;
  assign trail_tick = trail_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_sclk_burst_gen.sv
// Directed bench for spi_sclk_burst_gen: vector table of bursts plus
// hand-written waveform, back-to-back, stop and reset sequences.
module tb_spi_sclk_burst_gen;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] divisor;
  logic [7:0]  n_cycles;
  logic        cpol;
  logic        stop;
  logic        clock_out, lead_tick, trail_tick, busy, done;

  int total = 0;
  int bad   = 0;

  spi_sclk_burst_gen #(.CNT_W(16), .CYC_W(8)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .start     (start),
    .divisor   (divisor),
    .n_cycles  (n_cycles),
    .cpol      (cpol),
    .stop      (stop),
    .clock_out (clock_out),
    .lead_tick (lead_tick),
    .trail_tick(trail_tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  n;
    logic        cp;
    int          stop_at;
    int          mid_at;
    int          run;
    int          leads;
    int          trails;
    int          active;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic int outs();
    return {27'd0, clock_out, lead_tick, trail_tick, busy, done};
  endfunction

  // Starts a burst at the current negedge and observes it until done.
  task automatic run_burst(input logic [15:0] div, input logic [7:0] n, input logic cp,
                           input int stop_at, input int mid_at,
                           output int run, output int leads, output int trails,
                           output int active, output int done_cyc,
                           output int first_busy, output int overlap);
    run = 0; leads = 0; trails = 0; active = 0; done_cyc = 0;
    first_busy = 0; overlap = 0;
    divisor = div; n_cycles = n; cpol = cp; start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
    for (int j = 1; j <= 2000; j++) begin
      if (j == 1) first_busy = int'(busy);
      if (busy) run++;
      if (lead_tick) leads++;
      if (trail_tick) trails++;
      if (clock_out !== cp) active++;
      if (lead_tick && trail_tick) overlap++;
      if (done) begin
        done_cyc = j;
        start = 1'b0;
        stop  = 1'b0;
        break;
      end
      stop = (j == stop_at);
      if (j == mid_at) begin
        start = 1'b1; divisor = 16'd4; n_cycles = 8'd9; cpol = ~cp;
      end else begin
        start = 1'b0; divisor = div; n_cycles = n; cpol = cp;
      end
      @(negedge clock_in);
    end
  endtask

  int r, l, t, a, dc, fb, ov;
  int exp_o;

  initial begin
    //        div     n       cp    stop mid  run lead trail active
    vecs[0]  = '{16'd10, 8'd3,   1'b0, 0,   0,  30,  3,   3,   15};
    vecs[1]  = '{16'd5,  8'd2,   1'b1, 0,   0,  10,  2,   2,   6};
    vecs[2]  = '{16'd0,  8'd4,   1'b0, 0,   0,  8,   4,   4,   4};
    vecs[3]  = '{16'd1,  8'd3,   1'b1, 0,   0,  6,   3,   3,   3};
    vecs[4]  = '{16'd2,  8'd3,   1'b0, 0,   0,  6,   3,   3,   3};
    vecs[5]  = '{16'd3,  8'd1,   1'b0, 0,   0,  3,   1,   1,   2};
    vecs[6]  = '{16'd7,  8'd2,   1'b1, 0,   0,  14,  2,   2,   8};
    vecs[7]  = '{16'd0,  8'd0,   1'b1, 0,   0,  0,   0,   0,   0};
    vecs[8]  = '{16'd8,  8'd200, 1'b0, 27,  0,  32,  4,   4,   16};
    vecs[9]  = '{16'd4,  8'd10,  1'b0, 5,   0,  8,   2,   2,   4};
    vecs[10] = '{16'd6,  8'd3,   1'b0, 0,   5,  18,  3,   3,   9};
    vecs[11] = '{16'd9,  8'd1,   1'b1, 1,   0,  9,   1,   1,   5};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; cpol = 1'b0;
    divisor = 16'd10; n_cycles = 8'd3;
    repeat (3) @(negedge clock_in);
    check("reset_outs", outs(), 0);
    reset_n = 1'b1;
    @(negedge clock_in);
    check("idle_outs", outs(), 0);
    stop = 1'b1;
    @(negedge clock_in);
    stop = 1'b0;
    @(negedge clock_in);
    check("idle_stop_ignored", outs(), 0);

    // Exact waveform of the basic burst: start held in cycle 0.
    divisor = 16'd10; n_cycles = 8'd3; cpol = 1'b0; start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      exp_o = 0;
      if ((j >= 6 && j <= 10) || (j >= 16 && j <= 20) || (j >= 26 && j <= 30)) exp_o |= 16;
      if (j == 6 || j == 16 || j == 26) exp_o |= 8;
      if (j == 11 || j == 21 || j == 31) exp_o |= 4;
      if (j >= 1 && j <= 30) exp_o |= 2;
      if (j == 31) exp_o |= 1;
      check($sformatf("basic_cycle%0d", j), outs(), exp_o);
      @(negedge clock_in);
    end

    for (int i = 0; i < 12; i++) begin
      @(negedge clock_in);
      run_burst(vecs[i].div, vecs[i].n, vecs[i].cp, vecs[i].stop_at, vecs[i].mid_at,
                r, l, t, a, dc, fb, ov);
      check($sformatf("v%0d_busy_cycles", i), r, vecs[i].run);
      check($sformatf("v%0d_leads", i), l, vecs[i].leads);
      check($sformatf("v%0d_trails", i), t, vecs[i].trails);
      check($sformatf("v%0d_active", i), a, vecs[i].active);
      check($sformatf("v%0d_done_cycle", i), dc, vecs[i].run + 1);
      check($sformatf("v%0d_first_busy", i), fb, (vecs[i].n != 8'd0) ? 1 : 0);
      check($sformatf("v%0d_tick_overlap", i), ov, 0);
    end

    // Stop together with the final period: exactly one done.
    @(negedge clock_in);
    run_burst(16'd4, 8'd2, 1'b0, 8, 0, r, l, t, a, dc, fb, ov);
    check("stoplast_done_cycle", dc, 9);
    @(negedge clock_in);
    check("stoplast_no_second_done", outs(), 0);

    // Back-to-back: second start issued in the done cycle of the first.
    @(negedge clock_in);
    run_burst(16'd4, 8'd1, 1'b0, 0, 0, r, l, t, a, dc, fb, ov);
    check("b2b_first_done_cycle", dc, 5);
    run_burst(16'd2, 8'd2, 1'b1, 0, 0, r, l, t, a, dc, fb, ov);
    check("b2b_second_first_busy", fb, 1);
    check("b2b_second_busy_cycles", r, 4);
    check("b2b_second_trails", t, 2);
    check("b2b_second_done_cycle", dc, 5);
    @(negedge clock_in);
    check("b2b_idle_cpol1", outs(), 16);

    // Reset asserted during the active phase.
    cpol = 1'b0;
    @(negedge clock_in);
    divisor = 16'd10; n_cycles = 8'd3; cpol = 1'b0; start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
    repeat (7) @(negedge clock_in);
    check("rst_pre_active", outs(), 18);
    reset_n = 1'b0;
    #1;
    check("rst_immediate", outs(), 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock_in);
      check($sformatf("rst_held%0d", j), outs(), 0);
    end
    reset_n = 1'b1;
    @(negedge clock_in);
    check("rst_released_no_done", outs(), 0);
    @(negedge clock_in);
    run_burst(16'd4, 8'd2, 1'b0, 0, 0, r, l, t, a, dc, fb, ov);
    check("rst_after_busy_cycles", r, 8);
    check("rst_after_trails", t, 2);
    check("rst_after_done_cycle", dc, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
